uart_tx_fifo: RTL and testbench

//   Parametrised UART transmitter with an input FIFO and runtime frame format.
//   Bus-side logic pushes words; frames go out back-to-back, LSB first, timed by the shared oversample tick (b_tick).

---
 rtl/uart_tx_fifo.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with input FIFO; optional parity via UART_TX_PARITY_EN
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              b_tick,
  input  logic                              wr_en,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              stop2,
`ifdef UART_TX_PARITY_EN
  input  logic                              par_en,
  input  logic                              par_odd,
`endif
  output logic                              tx,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic                              fifo_full,
  output logic                              fifo_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              wr_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int TW = $clog2(OSR);
  localparam int BW = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              stop2_l_q, stop2_l_d;
`ifdef UART_TX_PARITY_EN
  logic              par_en_l_q, par_en_l_d;
  logic              par_bit_q, par_bit_d;
`endif
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic              bit_end, pop, push;

  // Next-state: bit timing, frame sequencing, FIFO bookkeeping and registered outputs
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    stop2_l_d = stop2_l_q;
`ifdef UART_TX_PARITY_EN
    par_en_l_d = par_en_l_q;
    par_bit_d  = par_bit_q;
`endif
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    bit_end   = b_tick && (tick_q == TW'(OSR-1));

    // Ticks only count inside a frame; a bit end wraps the counter
    if (state_q != S_IDLE && b_tick) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!empty_q) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_W-1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_l_q ? S_PARITY : S_STOP;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop2_l_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d = 1'b1;
            bit_d  = '0;
            if (!empty_q) pop = 1'b1;
            else state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop loads the next frame and its format; a b_tick in this cycle is not counted
    if (pop) begin
      state_d   = S_START;
      tick_d    = '0;
      bit_d     = '0;
      shift_d   = mem_q[rd_ptr_q];
      stop2_l_d = stop2;
`ifdef UART_TX_PARITY_EN
      par_en_l_d = par_en;
      par_bit_d  = par_odd ? ~(^mem_q[rd_ptr_q]) : (^mem_q[rd_ptr_q]);
`endif
      rd_ptr_d  = rd_ptr_q + AW'(1);
    end

    // A push into a full FIFO survives only if a pop frees a slot in the same cycle
    push  = wr_en && (!full_q || pop);
    ovf_d = wr_en && !push;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);
    full_d  = (level_d == LW'(FIFO_DEPTH));
    empty_d = (level_d == '0);
    busy_d  = (state_d != S_IDLE);

    // Line level follows the state held during this cycle
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_bit_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      stop2_l_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_l_q <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      stop2_l_q <= stop2_l_d;
`ifdef UART_TX_PARITY_EN
      par_en_l_q <= par_en_l_d;
      par_bit_q  <= par_bit_d;
`endif
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign fifo_level = level_q;
  assign wr_ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo (DATA_W=8, OSR=16, FIFO_DEPTH=4)
module tb_uart_tx_fifo;
  localparam int DW = 8;
  localparam int OSR = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_tick = 1'b0;
  logic wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic stop2 = 1'b0;
  bit cfg_pe = 1'b0;
  bit cfg_po = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic par_en = 1'b0;
  logic par_odd = 1'b0;
`endif
  logic tx, tx_busy, tx_done, fifo_full, fifo_empty, wr_ovf;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;

  uart_tx_fifo #(.DATA_W(DW), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .wr_en(wr_en), .wr_data(wr_data),
    .stop2(stop2),
`ifdef UART_TX_PARITY_EN
    .par_en(par_en), .par_odd(par_odd),
`endif
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_level(fifo_level), .wr_ovf(wr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bits;
    int          nb;
  } exp_t;

  exp_t sbq[$];
  int nchk = 0;
  int nerr = 0;
  int done_cnt = 0;
  int ovf_cnt = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity by ones-count, stop bits
  function automatic exp_t make_exp(input logic [DW-1:0] d, input bit s2, input bit pe, input bit po);
    exp_t e;
    int ones;
    int k;
    e.bits = '0;
    k = 1;
    for (int i = 0; i < DW; i++) begin
      e.bits[k] = d[i];
      k++;
    end
    if (pe) begin
      ones = $countones(d);
      e.bits[k] = po ? ((ones % 2) == 0) : ((ones % 2) == 1);
      k++;
    end
    e.bits[k] = 1'b1;
    k++;
    if (s2) begin
      e.bits[k] = 1'b1;
      k++;
    end
    e.nb = k;
    return e;
  endfunction

  // b_tick: one-cycle pulse every 4 clocks
  initial begin
    int tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tc++;
      b_tick = (tc % 4 == 0);
    end
  end

  // Monitor: decode each frame mid-bit, compare at tx_done against the scoreboard
  logic [15:0] got = '0;
  int nsamp = 0;
  int fcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      fcnt = 0; nsamp = 0; got = '0;
    end else begin
      if (wr_ovf) ovf_cnt++;
      if (tx_done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          chk("unexpected_tx_done", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("frame_bits", longint'(got), longint'(e.bits));
          chk("frame_nbits", nsamp, e.nb);
          chk("frame_ticks", fcnt, e.nb * OSR);
        end
        fcnt = (tx_busy && b_tick) ? 1 : 0;
        nsamp = 0;
        got = '0;
      end else if (tx_busy) begin
        if (b_tick) begin
          fcnt++;
          if (fcnt % OSR == OSR / 2) begin
            if (nsamp < 16) got[nsamp] = tx;
            nsamp++;
          end
        end
      end else begin
        fcnt = 0; nsamp = 0; got = '0;
      end
    end
  end

  // Caller is at posedge+1; returns at the next posedge+1
  task automatic push1(input logic [DW-1:0] d, input bit acc);
    wr_en = 1'b1;
    wr_data = d;
    if (acc) sbq.push_back(make_exp(d, stop2, cfg_pe, cfg_po));
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || tx_busy) && n < 30000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("idle_timeout", n < 30000, 1);
  endtask

  task automatic wait_done_neg();
    int n = 0;
    while (!tx_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", n < 5000, 1);
  endtask

  task automatic set_cfg(input bit s2, input bit pe, input bit po);
    stop2 = s2;
`ifdef UART_TX_PARITY_EN
    par_en = pe;
    par_odd = po;
    cfg_pe = pe;
    cfg_po = po;
`else
    cfg_pe = 1'b0;
    cfg_po = 1'b0;
    if (pe || po) cfg_pe = 1'b0;
`endif
  endtask

  initial begin
    int idle_bad;
    int ovf0, done0, n, cnt;
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idle_bad;
    int ovf0, done0, n, cnt;
    // 1. reset values and idle line
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_full", fifo_full, 0);
    rst_n = 1'b1;
    idle_bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || tx_done !== 1'b0) idle_bad++;
    end
    chk("idle_tx_high", idle_bad, 0);

    // 2. single 0x55 frame, latency and busy fall
    set_cfg(0, 0, 0);
    push1(8'h55, 1);
    chk("lat_edge0_tx", tx, 1);
    @(posedge clk); #1;
    chk("lat_edge1_tx", tx, 1);
    chk("lat_edge1_busy", tx_busy, 1);
    @(posedge clk); #1;
    chk("lat_edge2_tx", tx, 0);
    wait_done_neg();
    chk("busy_after_done", tx_busy, 0);
    wait_idle();

    // 3. two back-to-back frames
    push1(8'hA5, 1);
    push1(8'h3C, 1);
    chk("b2b_level1", fifo_level, 1);
    wait_done_neg();
    chk("b2b_level0", fifo_level, 0);
    chk("b2b_busy", tx_busy, 1);
    @(posedge clk); #1;
    wait_idle();
    chk("b2b_empty", fifo_empty, 1);

    // 4. overflow: six consecutive pushes from idle
    ovf0 = ovf_cnt;
    done0 = done_cnt;
    for (int i = 0; i < 5; i++) push1(8'(8'h10 + i), 1);
    push1(8'hEE, 0);
    chk("ovf_pulse", wr_ovf, 1);
    chk("ovf_full", fifo_full, 1);
    chk("ovf_level", fifo_level, DEPTH);
    @(posedge clk); #1;
    chk("ovf_one_cycle", wr_ovf, 0);
    wait_idle();
    chk("ovf_count", ovf_cnt - ovf0, 1);
    chk("ovf_frames", done_cnt - done0, 5);

`ifdef UART_TX_PARITY_EN
    // 5. parity with two stop bits
    set_cfg(1, 1, 0);
    push1(8'h07, 1);
    wait_idle();
    set_cfg(1, 1, 1);
    push1(8'h07, 1);
    wait_idle();
`endif

    // 6. reset mid-DATA, then recovery
    set_cfg(0, 0, 0);
    push1(8'hF0, 1);
    push1(8'h11, 1);
    repeat (160) @(posedge clk);
    #1;
    done0 = done_cnt;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_busy", tx_busy, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt - done0, 0);
    push1(8'h81, 1);
    wait_idle();

    // Random batches: fixed format per batch, format flipped mid-frame after the last pop
    for (int b = 0; b < 4; b++) begin
      set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cnt = $urandom_range(3, 8);
      for (int k = 0; k < cnt; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        n = 0;
        while (sbq.size() >= DEPTH && n < 5000) begin
          @(posedge clk);
          n++;
        end
        #1;
        if (n >= 5000) chk("space_timeout", 0, 1);
        push1(8'($urandom), 1);
      end
      n = 0;
      while (!fifo_empty && n < 20000) begin
        @(posedge clk);
        n++;
      end
      #1;
      chk("drain_timeout", n < 20000, 1);
      set_cfg(~stop2, ~cfg_pe, ~cfg_po);
      wait_idle();
      chk("rand_ovf_none", ovf_cnt - ovf0, 1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
